// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem read handshake, EX redirects,
// halt, and the IF/ID latch with a one-entry hold buffer for stalls.
module fetch_stage #(
  parameter int unsigned        WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        PCsel,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [WORD_W-1:0] jump_target,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              halt,
  output logic [WORD_W-1:0] inst_IFID,
  output logic [WORD_W-1:0] PC4_IFID,
  output logic              valid_IFID,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              halt_pend_q, halt_pend_d;

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] target;

  assign pc_plus4 = pc_q + WORD_W'(4);

  always_comb begin
    case (PCsel)
      2'b01:   target = branch_target;
      2'b10:   target = jump_target;
      2'b11:   target = jr_target;
      default: target = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_FETCH;
      pc_q        <= PC_INIT;
      pend_q      <= '0;
      buf_q       <= '0;
      inst_q      <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      buf_q       <= buf_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_d       = buf_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    halt_pend_d = halt_pend_q;

    if (state_q != S_HALT && redirect) begin
      valid_d     = 1'b0;
      halt_pend_d = 1'b0;
      buf_d       = '0;
      case (state_q)
        S_FETCH: begin
          if (ihit) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ihit) begin
            pc_d    = target;
            state_d = S_FETCH;
          end else begin
            pend_d = target;
          end
        end
        S_HOLD: begin
          pc_d    = target;
          state_d = S_FETCH;
        end
        default: ;
      endcase
    end else if (state_q != S_HALT && (halt || halt_pend_q)) begin
      // A halt seen while a request is in flight is remembered until that ihit.
      valid_d = 1'b0;
      if (state_q == S_HOLD || ihit) begin
        state_d     = S_HALT;
        halt_pend_d = 1'b0;
      end else begin
        halt_pend_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ihit) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_d   = imemload;
              state_d = S_HOLD;
            end else begin
              inst_d  = imemload;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_d  = buf_q;
            pc4_d   = pc_q;
            valid_d = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (ihit) begin
            pc_d    = pend_q;
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imemREN    = nRST && (state_q == S_FETCH || state_q == S_DRAIN);
    halted     = (state_q == S_HALT);
    imemaddr   = pc_q;
    inst_IFID  = inst_q;
    PC4_IFID   = pc4_q;
    valid_IFID = valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a queue-based reference model predicts the
// per-cycle outputs; a monitor pops and compares after every rising edge.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  PCsel = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic [31:0] inst_IFID;
  logic [31:0] PC4_IFID;
  logic        valid_IFID;
  logic        halted;

  logic        w_nrst = 1'b0;
  logic        w_ihit = 1'b0;
  logic [31:0] w_load;
  logic        w_ren;
  logic [31:0] w_addr;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic        w_halted;

  always #5 CLK = ~CLK;

  assign imemload = imemaddr ^ KEY;
  assign w_load   = w_addr ^ KEY;

  fetch_stage #(.WORD_W(32), .PC_INIT(32'h0000_0000)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .PCsel(PCsel), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .halt(halt),
    .inst_IFID(inst_IFID), .PC4_IFID(PC4_IFID), .valid_IFID(valid_IFID),
    .halted(halted)
  );

  fetch_stage #(.WORD_W(32), .PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .nRST(w_nrst), .ihit(w_ihit), .imemload(w_load),
    .imemREN(w_ren), .imemaddr(w_addr), .stall(1'b0),
    .redirect(1'b0), .PCsel(2'b00), .branch_target(32'h0),
    .jump_target(32'h0), .jr_target(32'h0), .halt(1'b0),
    .inst_IFID(w_inst), .PC4_IFID(w_pc4), .valid_IFID(w_valid),
    .halted(w_halted)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        ren;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: architectural PC, IF/ID contents, a buffered-word queue
  // and a pending-redirect queue (each at most one deep).
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid, m_halted, m_halt_wait;
  logic [31:0] hold_w[$];
  logic [31:0] drain_t[$];

  task automatic model_step(input logic n, input logic ih, input logic st,
                            input logic rd, input logic [1:0] sel,
                            input logic [31:0] bt, input logic [31:0] jt,
                            input logic [31:0] jrt, input logic hl);
    logic [31:0] tgt;
    logic [31:0] word;
    if (!n) begin
      m_pc = 32'h0; m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
      m_halted = 1'b0; m_halt_wait = 1'b0;
      hold_w.delete(); drain_t.delete();
      return;
    end
    if (m_halted) return;
    if (rd) begin
      case (sel)
        2'd1: tgt = bt;
        2'd2: tgt = jt;
        2'd3: tgt = jrt;
        default: tgt = m_pc + 32'd4;
      endcase
      m_valid = 1'b0;
      m_halt_wait = 1'b0;
      if (hold_w.size() > 0) begin
        hold_w.delete();
        m_pc = tgt;
      end else if (ih) begin
        drain_t.delete();
        m_pc = tgt;
      end else begin
        drain_t.delete();
        drain_t.push_back(tgt);
      end
      return;
    end
    if (hl || m_halt_wait) begin
      m_valid = 1'b0;
      if (hold_w.size() > 0 || ih) begin
        m_halted = 1'b1;
        m_halt_wait = 1'b0;
        hold_w.delete();
        drain_t.delete();
      end else begin
        m_halt_wait = 1'b1;
      end
      return;
    end
    if (drain_t.size() > 0) begin
      if (ih) m_pc = drain_t.pop_front();
      return;
    end
    if (hold_w.size() > 0) begin
      if (!st) begin
        m_inst  = hold_w.pop_front();
        m_pc4   = m_pc;
        m_valid = 1'b1;
      end
      return;
    end
    if (ih) begin
      word = m_pc ^ KEY;
      if (st) begin
        hold_w.push_back(word);
      end else begin
        m_inst  = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic n, input logic ih, input logic st,
                       input logic rd, input logic [1:0] sel,
                       input logic [31:0] tgt, input logic hl);
    exp_t e;
    logic [31:0] bt, jt, jrt;
    @(negedge CLK);
    bt  = (sel == 2'd1) ? tgt : ($urandom & 32'hFFFF_FFFC);
    jt  = (sel == 2'd2) ? tgt : ($urandom & 32'hFFFF_FFFC);
    jrt = (sel == 2'd3) ? tgt : ($urandom & 32'hFFFF_FFFC);
    nRST = n; ihit = ih; stall = st; redirect = rd; PCsel = sel;
    branch_target = bt; jump_target = jt; jr_target = jrt; halt = hl;
    model_step(n, ih, st, rd, sel, bt, jt, jrt, hl);
    e.addr   = m_pc;
    e.inst   = m_inst;
    e.pc4    = m_pc4;
    e.ren    = n && !m_halted && (hold_w.size() == 0);
    e.valid  = m_valid;
    e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic fetch_n(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) drive(1, 1, 0, 0, 2'd0, 32'h0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  exp_t mon_e, mon_a;
  initial begin : monitor
    forever begin
      @(posedge CLK);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {imemaddr, inst_IFID, PC4_IFID, imemREN, valid_IFID, halted};
        n_tests++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL cycle%0d: got addr=%h inst=%h pc4=%h ren=%b v=%b h=%b want addr=%h inst=%h pc4=%h ren=%b v=%b h=%b",
                   cyc, mon_a.addr, mon_a.inst, mon_a.pc4, mon_a.ren, mon_a.valid, mon_a.halted,
                   mon_e.addr, mon_e.inst, mon_e.pc4, mon_e.ren, mon_e.valid, mon_e.halted);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic ih, st, rd, hl, n;
    logic [1:0] sel;
    logic [31:0] tgt;

    // PC wrap-around with PC_INIT = FFFFFFFC.
    @(negedge CLK); w_nrst = 1'b0; w_ihit = 1'b0;
    @(posedge CLK); #2;
    check("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_reset_ren", {31'b0, w_ren}, 32'h0);
    check("wrap_reset_valid", {30'b0, w_valid, w_halted}, 32'h0);
    @(negedge CLK); w_nrst = 1'b1; w_ihit = 1'b1;
    @(posedge CLK); #2;
    check("wrap_addr", w_addr, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_inst", w_inst, 32'hFFFF_FFFC ^ KEY);
    check("wrap_valid", {31'b0, w_valid}, 32'h1);
    @(negedge CLK); w_ihit = 1'b0;

    // Straight-line fetch.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(4);

    // Stall-on-hit at PC=8 held for three cycles, then release.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(2);
    for (int unsigned i = 0; i < 3; i++) drive(1, 1, 1, 0, 2'd0, 32'h0, 0);
    drive(1, 1, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(2);

    // jr redirect while the fetch at 0x20 is outstanding.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(8);
    drive(1, 0, 0, 1, 2'd3, 32'h100, 0);
    drive(1, 0, 0, 0, 2'd0, 32'h0, 0);
    drive(1, 0, 0, 0, 2'd0, 32'h0, 0);
    drive(1, 1, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(2);

    // Branch redirect coinciding with ihit and stall.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(2);
    drive(1, 1, 1, 1, 2'd1, 32'h40, 0);
    fetch_n(2);

    // Halt at 0x18, PC frozen, then reset.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(6);
    drive(1, 1, 0, 0, 2'd0, 32'h0, 1);
    for (int unsigned i = 0; i < 10; i++) drive(1, 1'($urandom_range(0, 1)), 0, 0, 2'd0, 32'h0, 0);
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    fetch_n(2);

    // Randomized traffic.
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    for (int unsigned i = 0; i < 3000; i++) begin
      n   = !(($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0));
      ih  = ($urandom_range(0, 9) < 6);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      sel = 2'($urandom_range(0, 3));
      tgt = $urandom & 32'hFFFF_FFFC;
      hl  = !st && ($urandom_range(0, 59) == 0);
      drive(n, ih, st, rd, sel, tgt, hl);
    end

    @(negedge CLK);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of each core's five-stage pipeline. Directly upstream of the IF/ID latch, which feeds the control unit's inst/imemload input.
- Owns the PC and the instruction-memory request handshake (imemREN/ihit).
- Applies redirects from EX: branch, jump, jr.
- Presents fetched instructions with a valid bit.
- Holds a fetched instruction across downstream stalls and squashes wrong-path fetches.

Parameters:
PC_INIT, 32'h00000000, PC value loaded at reset
WORD_W, 32, instruction/address width

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  synchronous active-low reset
ihit  input  1  instruction memory returns imemload for imemaddr this cycle
imemload  input  32  fetched instruction word
imemREN  output  1  instruction read request
imemaddr  output  32  instruction address (current PC)
stall  input  1  hazard unit: IF/ID must hold its contents
redirect  input  1  EX resolved a taken control transfer this cycle
PCsel  input  2  redirect source: 01 branch_target, 10 jump_target, 11 jr_target
branch_target  input  32  PC-relative branch destination
jump_target  input  32  J/JAL destination
jr_target  input  32  register-jump destination
halt  input  1  halt decoded (ID); stop fetching
inst_IFID  output  32  instruction to decode
PC4_IFID  output  32  PC+4 of that instruction
valid_IFID  output  1  inst_IFID is a real instruction (0 = bubble)
halted  output  1  fetch permanently stopped

Behaviour:
- Interface: one clock, CLK. Reset nRST is synchronous and active-low: sampled on the CLK rising edge, and takes priority over all other inputs.
- Reset values: PC=PC_INIT, state=FETCH, imemREN=0 during the reset cycle then 1, inst_IFID=0, PC4_IFID=0, valid_IFID=0, halted=0.
- Address: imemaddr=PC at all times. PC+4 uses modulo-2^32 arithmetic, so 32'hFFFFFFFC+4 = 0. Redirect targets are used as given, with no alignment check.
- States: FETCH, HOLD, DRAIN, HALT.
- FETCH: imemREN=1. The PC and address stay stable until ihit.
  - ihit && !stall && !redirect: IF/ID <= {imemload, PC+4, valid=1}; PC <= PC+4.
  - ihit && stall && !redirect: the word goes to an internal hold buffer; PC <= PC+4; go to HOLD. IF/ID is unchanged.
  - !ihit && !stall: valid_IFID <= 0 (bubble inserted).
  - !ihit && stall: IF/ID is unchanged.
- HOLD: imemREN=0. When stall deasserts, IF/ID <= buffered word with valid=1, then go to FETCH. One-entry buffer: no further fetch is issued while in HOLD.
- Redirect (any state except HALT, highest priority after reset). IF/ID valid <= 0 and the hold buffer is cleared, including while stall is asserted.
  - Target is chosen by PCsel. PCsel=00 with redirect=1 means PC <= PC+4 (treated as no-op target).
  - In FETCH with no ihit that cycle: the outstanding request is drained. The target is latched into a pending register, go to DRAIN, imemaddr stays on the old PC, and imemREN=1.
  - In FETCH with ihit the same cycle: the fetched word is discarded and PC <= target. Stay in FETCH.
  - In HOLD: PC <= target, go to FETCH.
- DRAIN: imemREN=1 at the old address. On ihit the word is discarded, PC <= pending target, and go to FETCH. A second redirect while in DRAIN overwrites the pending target.
- Halt:
  - halt=1 and no redirect that cycle: valid_IFID <= 0, go to HALT. Any in-flight request is abandoned only after its ihit (finish DRAIN first if in DRAIN).
  - In HALT: imemREN=0, halted=1, and the PC is frozen. Only reset leaves HALT.
  - If halt and redirect arrive in the same cycle, redirect wins; halt is ignored as wrong-path.
- stall with redirect: the redirect still squashes, so IF/ID is cleared even though stall=1.
- Reset mid-DRAIN or mid-HOLD: all state is discarded and the PC returns to PC_INIT.

Test Plan:
1. Reset, then ihit every cycle with imemload=PC^32'hA5A5A5A5 -> imemaddr 0,4,8,C on consecutive cycles; valid_IFID=1 from cycle 2 with PC4_IFID 4,8,C.
2. ihit at PC=8 while stall=1 for 3 cycles -> IF/ID unchanged for 3 cycles, imemREN=0 in HOLD; the cycle after stall drops, inst_IFID=word@8, PC4_IFID=C, then the fetch of 0xC.
3. redirect with PCsel=11, jr_target=0x100, while the fetch at 0x20 is pending with no ihit -> imemaddr stays 0x20 until ihit, that word is dropped (valid_IFID=0), then imemaddr=0x100.
4. redirect with PCsel=01, branch_target=0x40, in the same cycle as ihit and stall=1 -> valid_IFID=0 next cycle, no HOLD, imemaddr=0x40.
5. halt=1 at PC=0x18 -> the next cycle has halted=1, imemREN=0, valid_IFID=0; imemaddr stays constant for 10 cycles; nRST=0 -> imemaddr=PC_INIT and halted=0.
6. PC_INIT=32'hFFFFFFFC with ihit -> next imemaddr=0, PC4_IFID=0.
